multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Sequencing controller for the multi-cycle RV32I datapath variant. Each instruction runs over 3–5 clock cycles through a Moore state machine. The controller drives the datapath's PC, IR and register-file write enables, the mux selects, the immediate format and the ALU function. It also stalls on a shared instruction/data memory through a ready handshake. It sits beside the datapath and decodes the latched instruction register fields.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset; rst=0 forces FETCH and zeroes all outputs
- opcode  in  7  IR[6:0], stable from the cycle after FETCH completes
- funct3  in  3  IR[14:12]
- funct7_5  in  1  IR[30]
- zero  in  1  ALU result == 0 (current cycle)
- neg  in  1  ALU result bit 31 (current cycle)
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access active
- mem_write  out  1  store strobe, valid with mem_req
- adr_src  out  1  0 = PC, 1 = ALUOut as memory address
- ir_write  out  1  latch instruction register and old_pc
- pc_write  out  1  load PC from result bus
- reg_write  out  1  write rd from result bus
- alu_src_a  out  2  00 = PC, 01 = old_pc, 10 = rs1 register
- alu_src_b  out  2  00 = rs2 register, 01 = immediate, 10 = constant 4
- alu_func  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 101 xor
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- result_src  out  2  00 = ALUOut, 01 = data register, 10 = ALU result, 11 = immediate
- inst_done  out  1  one-cycle pulse in the last cycle of each instruction
- halt  out  1  high in ERROR state

## Operation
- Opcodes: R 0110011, I 0010011, LW 0000011, SW 0100011, BR 1100011, JAL 1101111, JALR 1100111, LUI 0110111. Any other opcode goes DECODE -> ERROR.
- Defaults in every state: all enables 0, mem_req 0, selects 0, alu_func add.
- FETCH:
  - drives mem_req, adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10.
  - ir_write and pc_write are asserted only while mem_ready=1; the state is held otherwise.
  - exits to DECODE when mem_ready=1.
- DECODE:
  - drives alu_src_a=01, alu_src_b=01, add.
  - imm_src is J for JAL, B otherwise, so ALUOut holds the branch/jump target.
  - next state: R->EXEC_R; I->EXEC_I; JALR->EXEC_I; LW/SW->MEM_ADDR; BR->BRANCH; JAL->JUMP; LUI->LUI.
- EXEC_R:
  - drives a=10, b=00.
  - funct3 decode: 000 gives add (funct7_5=0) or sub (funct7_5=1); 111 and; 110 or; 100 xor; 010 slt; others go to ERROR.
  - next state ALU_WB.
- EXEC_I:
  - drives a=10, b=01, imm I.
  - For JALR: add, next state JUMP.
  - Otherwise: funct3 decode as EXEC_R with funct7_5 ignored, next state ALU_WB.
- ALU_WB: result_src=00, reg_write, inst_done; next state FETCH.
- MEM_ADDR: a=10, b=01, add, imm I (LW) or S (SW); next state MEM_READ (LW) or MEM_WRITE (SW).
- MEM_READ: mem_req, adr_src=1; holds until mem_ready, then MEM_WB.
- MEM_WB: result_src=01, reg_write, inst_done; next state FETCH.
- MEM_WRITE: mem_req, mem_write, adr_src=1; holds until mem_ready, then inst_done and FETCH.
- BRANCH:
  - drives a=10, b=00, sub, result_src=00, inst_done.
  - taken condition by funct3: 000 zero; 001 !zero; 100 neg; 101 !neg. pc_write = taken.
  - other funct3 values go to ERROR with no pc_write.
  - next state FETCH.
- JUMP:
  - drives result_src=00 and pc_write (target from ALUOut).
  - also drives a=01, b=10, add, so old_pc+4 is latched into ALUOut.
  - next state ALU_WB.
- LUI: imm U, result_src=11, reg_write, inst_done; next state FETCH.
- ERROR: halt=1, all enables 0; the only exit is reset.

## Timing
- All outputs are Moore decodes of state, except the mem_ready gating in FETCH, MEM_READ and MEM_WRITE and the taken gating in BRANCH.
- Cycle counts with zero wait states:
  - BR: 3; LUI: 3
  - R, I, SW, JAL: 4
  - LW, JALR: 5
- Each cycle with mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds 1 cycle; mem_req stays high and no other state advances.
- inst_done is exactly 1 cycle per retired instruction. It is never asserted in ERROR or in FETCH.
- While rst=0: every output is 0, including mem_req and halt.
- After reset release: the first rising edge sees FETCH with mem_req=1.
- Reset mid-instruction (any state, including a stalled access): outputs drop to 0 immediately, asynchronously. No partial register or PC write occurs. Execution restarts at FETCH.
- mem_ready outside memory states is ignored.

## Test plan
- ADD (R, funct3 000, funct7_5 0), mem_ready=1 -> states FETCH, DECODE, EXEC_R, ALU_WB; alu_func 000 in EXEC_R; reg_write only in cycle 4; inst_done only in cycle 4.
- LW with mem_ready held 0 for 3 cycles in MEM_READ -> MEM_READ lasts 4 cycles with mem_req=1 and adr_src=1; total 8 cycles; reg_write with result_src=01 in MEM_WB.
- BNE with zero=1, then with zero=0 -> 3 cycles each; pc_write 0 when zero=1, pc_write 1 with result_src=00 when zero=0.
- JALR -> FETCH, DECODE, EXEC_I (add, imm I), JUMP (pc_write), ALU_WB (reg_write); total 5 cycles.
- Opcode 1111111 -> DECODE then ERROR; halt=1 and no enables for 10 cycles; rst=0 then 1 -> FETCH with halt=0.
- Assert rst=0 in MEM_WRITE while stalled -> mem_write and mem_req drop the same cycle; after release the first state is FETCH.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - control/status bundle between multicycle controller and datapath
interface multicycle_controller_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       neg;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_func;
    logic [2:0] imm_src;
    logic [1:0] result_src;
    logic       inst_done;
    logic       halt;

    // controller side: decodes IR fields and flags, drives datapath controls
    modport master (
        input  opcode, funct3, funct7_5, zero, neg, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_func, imm_src, result_src,
               inst_done, halt
    );

    // datapath/memory side
    modport slave (
        output opcode, funct3, funct7_5, zero, neg, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_func, imm_src, result_src,
               inst_done, halt
    );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore sequencing FSM for the multi-cycle RV32I datapath
module multicycle_controller (
    input  logic                            clk,
    input  logic                            rst,
    multicycle_controller_if.master         bus
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_OLDPC  = 2'b01;
    localparam logic [1:0] SRCA_RS1    = 2'b10;
    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_DATA    = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;
    localparam logic [1:0] RES_IMM     = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_R    = 4'd2,
        S_EXEC_I    = 4'd3,
        S_ALU_WB    = 4'd4,
        S_MEM_ADDR  = 4'd5,
        S_MEM_READ  = 4'd6,
        S_MEM_WB    = 4'd7,
        S_MEM_WRITE = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_LUI       = 4'd11,
        S_ERROR     = 4'd12
    } state_t;

    state_t state;
    state_t next_state;

    // raw Moore decodes before the reset gate
    logic       mem_req_c;
    logic       mem_write_c;
    logic       adr_src_c;
    logic       ir_write_c;
    logic       pc_write_c;
    logic       reg_write_c;
    logic [1:0] alu_src_a_c;
    logic [1:0] alu_src_b_c;
    logic [2:0] alu_func_c;
    logic [2:0] imm_src_c;
    logic [1:0] result_src_c;
    logic       inst_done_c;
    logic       halt_c;

    logic       op_ok;
    logic [2:0] op_func;
    logic       br_ok;
    logic       br_taken;

    // Returns {legal, alu_func}; funct7_5 only distinguishes add/sub when use_f75 is set
    function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                              input logic       f75,
                                              input logic       use_f75);
        logic [3:0] r;
        case (f3)
            3'b000:  r = {1'b1, (use_f75 && f75) ? ALU_SUB : ALU_ADD};
            3'b111:  r = {1'b1, ALU_AND};
            3'b110:  r = {1'b1, ALU_OR};
            3'b100:  r = {1'b1, ALU_XOR};
            3'b010:  r = {1'b1, ALU_SLT};
            default: r = {1'b0, ALU_ADD};
        endcase
        return r;
    endfunction

    // Branch condition from subtraction flags; returns {legal, taken}
    function automatic logic [1:0] branch_decode(input logic [2:0] f3,
                                                 input logic       z,
                                                 input logic       n);
        logic [1:0] r;
        case (f3)
            3'b000:  r = {1'b1, z};
            3'b001:  r = {1'b1, ~z};
            3'b100:  r = {1'b1, n};
            3'b101:  r = {1'b1, ~n};
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    // Field decoders shared by EXEC_R, EXEC_I and BRANCH
    always_comb begin
        op_ok   = 1'b0;
        op_func = ALU_ADD;
        {op_ok, op_func} = alu_decode(bus.funct3, bus.funct7_5, state == S_EXEC_R);
        {br_ok, br_taken} = branch_decode(bus.funct3, bus.zero, bus.neg);
    end

    // State register; reset always restarts at FETCH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control decode; every output defaults to idle/add
    always_comb begin
        next_state   = state;
        mem_req_c    = 1'b0;
        mem_write_c  = 1'b0;
        adr_src_c    = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        alu_src_a_c  = SRCA_PC;
        alu_src_b_c  = SRCB_RS2;
        alu_func_c   = ALU_ADD;
        imm_src_c    = IMM_I;
        result_src_c = RES_ALUOUT;
        inst_done_c  = 1'b0;
        halt_c       = 1'b0;

        case (state)
            S_FETCH: begin
                // PC+4 goes straight from the ALU onto the result bus
                mem_req_c    = 1'b1;
                adr_src_c    = 1'b0;
                alu_src_a_c  = SRCA_PC;
                alu_src_b_c  = SRCB_FOUR;
                result_src_c = RES_ALU;
                if (bus.mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    next_state = S_DECODE;
                end
            end

            S_DECODE: begin
                // speculatively compute old_pc + imm as a branch/jump target
                alu_src_a_c = SRCA_OLDPC;
                alu_src_b_c = SRCB_IMM;
                imm_src_c   = (bus.opcode == OP_JAL) ? IMM_J : IMM_B;
                case (bus.opcode)
                    OP_R:    next_state = S_EXEC_R;
                    OP_I:    next_state = S_EXEC_I;
                    OP_JALR: next_state = S_EXEC_I;
                    OP_LW:   next_state = S_MEM_ADDR;
                    OP_SW:   next_state = S_MEM_ADDR;
                    OP_BR:   next_state = S_BRANCH;
                    OP_JAL:  next_state = S_JUMP;
                    OP_LUI:  next_state = S_LUI;
                    default: next_state = S_ERROR;
                endcase
            end

            S_EXEC_R: begin
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_RS2;
                if (op_ok) begin
                    alu_func_c = op_func;
                    next_state = S_ALU_WB;
                end else begin
                    next_state = S_ERROR;
                end
            end

            S_EXEC_I: begin
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_IMM;
                imm_src_c   = IMM_I;
                if (bus.opcode == OP_JALR) begin
                    // rs1 + imm is the jump target, taken in JUMP
                    next_state = S_JUMP;
                end else if (op_ok) begin
                    alu_func_c = op_func;
                    next_state = S_ALU_WB;
                end else begin
                    next_state = S_ERROR;
                end
            end

            S_ALU_WB: begin
                result_src_c = RES_ALUOUT;
                reg_write_c  = 1'b1;
                inst_done_c  = 1'b1;
                next_state   = S_FETCH;
            end

            S_MEM_ADDR: begin
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_IMM;
                imm_src_c   = (bus.opcode == OP_SW) ? IMM_S : IMM_I;
                next_state  = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end

            S_MEM_READ: begin
                mem_req_c = 1'b1;
                adr_src_c = 1'b1;
                if (bus.mem_ready) begin
                    next_state = S_MEM_WB;
                end
            end

            S_MEM_WB: begin
                result_src_c = RES_DATA;
                reg_write_c  = 1'b1;
                inst_done_c  = 1'b1;
                next_state   = S_FETCH;
            end

            S_MEM_WRITE: begin
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                adr_src_c   = 1'b1;
                if (bus.mem_ready) begin
                    inst_done_c = 1'b1;
                    next_state  = S_FETCH;
                end
            end

            S_BRANCH: begin
                // rs1 - rs2 drives the flags; ALUOut already holds the target
                alu_src_a_c  = SRCA_RS1;
                alu_src_b_c  = SRCB_RS2;
                alu_func_c   = ALU_SUB;
                result_src_c = RES_ALUOUT;
                if (br_ok) begin
                    pc_write_c  = br_taken;
                    inst_done_c = 1'b1;
                    next_state  = S_FETCH;
                end else begin
                    next_state  = S_ERROR;
                end
            end

            S_JUMP: begin
                // load target into PC while old_pc + 4 lands in ALUOut for the link write
                result_src_c = RES_ALUOUT;
                pc_write_c   = 1'b1;
                alu_src_a_c  = SRCA_OLDPC;
                alu_src_b_c  = SRCB_FOUR;
                alu_func_c   = ALU_ADD;
                next_state   = S_ALU_WB;
            end

            S_LUI: begin
                imm_src_c    = IMM_U;
                result_src_c = RES_IMM;
                reg_write_c  = 1'b1;
                inst_done_c  = 1'b1;
                next_state   = S_FETCH;
            end

            S_ERROR: begin
                halt_c     = 1'b1;
                next_state = S_ERROR;
            end

            default: begin
                next_state = S_ERROR;
            end
        endcase
    end

    // Reset gate: outputs fall to zero the moment rst goes low, even mid-access
    always_comb begin
        bus.mem_req    = rst & mem_req_c;
        bus.mem_write  = rst & mem_write_c;
        bus.adr_src    = rst & adr_src_c;
        bus.ir_write   = rst & ir_write_c;
        bus.pc_write   = rst & pc_write_c;
        bus.reg_write  = rst & reg_write_c;
        bus.alu_src_a  = rst ? alu_src_a_c  : 2'b00;
        bus.alu_src_b  = rst ? alu_src_b_c  : 2'b00;
        bus.alu_func   = rst ? alu_func_c   : 3'b000;
        bus.imm_src    = rst ? imm_src_c    : 3'b000;
        bus.result_src = rst ? result_src_c : 2'b00;
        bus.inst_done  = rst & inst_done_c;
        bus.halt       = rst & halt_c;
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;

    logic clk;
    logic rst;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [19:0] vec;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, a, b, func, imm, res, done, halt}
    function automatic logic [19:0] v(input logic mreq, input logic mwr, input logic adr,
                                      input logic irw, input logic pcw, input logic rw,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [2:0] f, input logic [2:0] imm,
                                      input logic [1:0] res, input logic done, input logic hlt);
        return {mreq, mwr, adr, irw, pcw, rw, a, b, f, imm, res, done, hlt};
    endfunction

    logic [19:0] got;
    assign got = {bus.mem_req, bus.mem_write, bus.adr_src, bus.ir_write, bus.pc_write,
                  bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_func, bus.imm_src,
                  bus.result_src, bus.inst_done, bus.halt};

    // Monitor: compares whatever the DUT presents against the oldest expectation
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (got !== e.vec) begin
                bad++;
                $display("FAIL %s got=%b required=%b", e.name, got, e.vec);
            end
        end
    end

    task automatic cyc(input string nm, input logic [19:0] e);
        exp_t x;
        x.name = nm;
        x.vec  = e;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic set_inst(input logic [6:0] op, input logic [2:0] f3, input logic f75);
        bus.opcode   = op;
        bus.funct3   = f3;
        bus.funct7_5 = f75;
    endtask

    logic [19:0] ZERO, F_RDY, F_STL, D_B, D_J, WB, MWB, MA_LW, MA_SW, MR, MW_STL, MW_RDY;
    logic [19:0] JMP, EI_ADD, EI_OR, LUI_V, HALT_V;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ZERO   = '0;
        F_RDY  = v(1,0,0,1,1,0,2'b00,2'b10,3'b000,3'b000,2'b10,0,0);
        F_STL  = v(1,0,0,0,0,0,2'b00,2'b10,3'b000,3'b000,2'b10,0,0);
        D_B    = v(0,0,0,0,0,0,2'b01,2'b01,3'b000,3'b010,2'b00,0,0);
        D_J    = v(0,0,0,0,0,0,2'b01,2'b01,3'b000,3'b011,2'b00,0,0);
        WB     = v(0,0,0,0,0,1,2'b00,2'b00,3'b000,3'b000,2'b00,1,0);
        MWB    = v(0,0,0,0,0,1,2'b00,2'b00,3'b000,3'b000,2'b01,1,0);
        MA_LW  = v(0,0,0,0,0,0,2'b10,2'b01,3'b000,3'b000,2'b00,0,0);
        MA_SW  = v(0,0,0,0,0,0,2'b10,2'b01,3'b000,3'b001,2'b00,0,0);
        MR     = v(1,0,1,0,0,0,2'b00,2'b00,3'b000,3'b000,2'b00,0,0);
        MW_STL = v(1,1,1,0,0,0,2'b00,2'b00,3'b000,3'b000,2'b00,0,0);
        MW_RDY = v(1,1,1,0,0,0,2'b00,2'b00,3'b000,3'b000,2'b00,1,0);
        JMP    = v(0,0,0,0,1,0,2'b01,2'b10,3'b000,3'b000,2'b00,0,0);
        EI_ADD = v(0,0,0,0,0,0,2'b10,2'b01,3'b000,3'b000,2'b00,0,0);
        EI_OR  = v(0,0,0,0,0,0,2'b10,2'b01,3'b011,3'b000,2'b00,0,0);
        LUI_V  = v(0,0,0,0,0,1,2'b00,2'b00,3'b000,3'b100,2'b11,1,0);
        HALT_V = v(0,0,0,0,0,0,2'b00,2'b00,3'b000,3'b000,2'b00,0,1);

        rst = 1'b0;
        set_inst(7'b0110011, 3'b000, 1'b0);
        bus.zero = 1'b0;
        bus.neg = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // reset state: every output low, even with mem_ready high
        cyc("reset0", ZERO);
        cyc("reset1", ZERO);

        // ADD
        rst = 1'b1;
        cyc("add_fetch", F_RDY);
        cyc("add_decode", D_B);
        cyc("add_exec", v(0,0,0,0,0,0,2'b10,2'b00,3'b000,3'b000,2'b00,0,0));
        cyc("add_wb", WB);

        // SUB, XOR, SLT, AND
        set_inst(7'b0110011, 3'b000, 1'b1);
        cyc("sub_fetch", F_RDY); cyc("sub_decode", D_B);
        cyc("sub_exec", v(0,0,0,0,0,0,2'b10,2'b00,3'b001,3'b000,2'b00,0,0));
        cyc("sub_wb", WB);
        set_inst(7'b0110011, 3'b100, 1'b0);
        cyc("xor_fetch", F_RDY); cyc("xor_decode", D_B);
        cyc("xor_exec", v(0,0,0,0,0,0,2'b10,2'b00,3'b101,3'b000,2'b00,0,0));
        cyc("xor_wb", WB);
        set_inst(7'b0110011, 3'b010, 1'b0);
        cyc("slt_fetch", F_RDY); cyc("slt_decode", D_B);
        cyc("slt_exec", v(0,0,0,0,0,0,2'b10,2'b00,3'b100,3'b000,2'b00,0,0));
        cyc("slt_wb", WB);
        set_inst(7'b0110011, 3'b111, 1'b0);
        cyc("and_fetch", F_RDY); cyc("and_decode", D_B);
        cyc("and_exec", v(0,0,0,0,0,0,2'b10,2'b00,3'b010,3'b000,2'b00,0,0));
        cyc("and_wb", WB);

        // ORI with funct7_5 set (ignored for I-type), one fetch wait state
        set_inst(7'b0010011, 3'b110, 1'b1);
        bus.mem_ready = 1'b0;
        cyc("ori_fetch_stall", F_STL);
        bus.mem_ready = 1'b1;
        cyc("ori_fetch", F_RDY); cyc("ori_decode", D_B);
        cyc("ori_exec", EI_OR); cyc("ori_wb", WB);

        // LW with three wait states in MEM_READ: 8 cycles
        set_inst(7'b0000011, 3'b010, 1'b0);
        cyc("lw_fetch", F_RDY); cyc("lw_decode", D_B); cyc("lw_addr", MA_LW);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("lw_read_stall", MR);
        bus.mem_ready = 1'b1;
        cyc("lw_read", MR);
        cyc("lw_wb", MWB);

        // SW, zero wait
        set_inst(7'b0100011, 3'b010, 1'b0);
        cyc("sw_fetch", F_RDY); cyc("sw_decode", D_B); cyc("sw_addr", MA_SW);
        cyc("sw_write", MW_RDY);

        // BNE not taken (zero=1), then taken (zero=0)
        set_inst(7'b1100011, 3'b001, 1'b0);
        bus.zero = 1'b1;
        cyc("bne_nt_fetch", F_RDY); cyc("bne_nt_decode", D_B);
        cyc("bne_nt_branch", v(0,0,0,0,0,0,2'b10,2'b00,3'b001,3'b000,2'b00,1,0));
        bus.zero = 1'b0;
        cyc("bne_t_fetch", F_RDY); cyc("bne_t_decode", D_B);
        cyc("bne_t_branch", v(0,0,0,0,1,0,2'b10,2'b00,3'b001,3'b000,2'b00,1,0));

        // BGE with neg=1 is not taken, BLT with neg=1 is taken
        set_inst(7'b1100011, 3'b101, 1'b0);
        bus.neg = 1'b1;
        cyc("bge_fetch", F_RDY); cyc("bge_decode", D_B);
        cyc("bge_branch", v(0,0,0,0,0,0,2'b10,2'b00,3'b001,3'b000,2'b00,1,0));
        set_inst(7'b1100011, 3'b100, 1'b0);
        cyc("blt_fetch", F_RDY); cyc("blt_decode", D_B);
        cyc("blt_branch", v(0,0,0,0,1,0,2'b10,2'b00,3'b001,3'b000,2'b00,1,0));
        bus.neg = 1'b0;

        // JAL with mem_ready low outside memory states (must not stall)
        set_inst(7'b1101111, 3'b000, 1'b0);
        cyc("jal_fetch", F_RDY);
        bus.mem_ready = 1'b0;
        cyc("jal_decode", D_J); cyc("jal_jump", JMP); cyc("jal_wb", WB);
        bus.mem_ready = 1'b1;

        // JALR: 5 cycles
        set_inst(7'b1100111, 3'b000, 1'b0);
        cyc("jalr_fetch", F_RDY); cyc("jalr_decode", D_B); cyc("jalr_exec", EI_ADD);
        cyc("jalr_jump", JMP); cyc("jalr_wb", WB);

        // LUI: 3 cycles
        set_inst(7'b0110111, 3'b000, 1'b0);
        cyc("lui_fetch", F_RDY); cyc("lui_decode", D_B); cyc("lui_exec", LUI_V);

        // SW stalled, then reset mid-access
        set_inst(7'b0100011, 3'b000, 1'b0);
        cyc("swr_fetch", F_RDY); cyc("swr_decode", D_B); cyc("swr_addr", MA_SW);
        bus.mem_ready = 1'b0;
        cyc("swr_write_stall", MW_STL);
        rst = 1'b0;
        cyc("swr_reset_drop", ZERO);
        bus.mem_ready = 1'b1;
        cyc("swr_reset_hold", ZERO);
        rst = 1'b1;
        set_inst(7'b0110111, 3'b000, 1'b0);
        cyc("swr_refetch", F_RDY); cyc("swr_lui_decode", D_B); cyc("swr_lui", LUI_V);

        // illegal opcode: ERROR held for 10 cycles regardless of mem_ready
        set_inst(7'b1111111, 3'b000, 1'b0);
        cyc("ill_fetch", F_RDY); cyc("ill_decode", D_B);
        for (int i = 0; i < 10; i++) begin
            bus.mem_ready = i[0];
            cyc("ill_halt", HALT_V);
        end
        rst = 1'b0;
        cyc("ill_reset", ZERO);
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        set_inst(7'b0110011, 3'b001, 1'b0);
        cyc("ill_refetch", F_RDY);

        // illegal R funct3 falls into ERROR after EXEC_R
        cyc("badf3_decode", D_B);
        cyc("badf3_exec", v(0,0,0,0,0,0,2'b10,2'b00,3'b000,3'b000,2'b00,0,0));
        cyc("badf3_halt", HALT_V);
        cyc("badf3_halt2", HALT_V);

        @(posedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d required=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
